dpram_drain: RTL

- Consumer end of the waveform-buffer reader's DPRAM readback handshake (run / busy / done).
- The reader fills the 32-bit DPRAM and pulses dpram_run with dpram_len. This block takes ownership (busy), reads the words back and serialises them as a valid/ready byte stream toward the host link.
- It then releases busy so the reader can refill.
- It replaces the behavioural DPRAM user used in the reader bench and sits between the DPRAM read port and the host byte interface.

---
 rtl/dpram_drain_pkg.sv | 25 ++
 rtl/dpram_word_serializer.sv | 38 +++
 rtl/dpram_drain.sv | 105 ++++++++++
 3 files changed

// File: rtl/dpram_drain_pkg.sv
// Shared definitions for the waveform-buffer DPRAM readback handshake.
`timescale 1ns/1ps
package dpram_drain_pkg;

  localparam int unsigned DPRAM_ADDR_W = 10;
  localparam int unsigned DPRAM_LEN_W  = 16;
  localparam int unsigned WORD_W       = 32;
  localparam int unsigned BYTE_W       = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_LATCH = 3'd2,
    ST_SEND  = 3'd3,
    ST_FIN   = 3'd4
  } drain_state_t;

  // Byte capacity of a DPRAM of 2^addr_w 32-bit words.
  function automatic int unsigned byte_cap(input int unsigned addr_w);
    return 32'd4 << addr_w;
  endfunction

  localparam int unsigned DPRAM_BYTE_CAP = byte_cap(DPRAM_ADDR_W);

endpackage

// File: rtl/dpram_word_serializer.sv
// Loads one DPRAM word and presents it MSB-first as a valid/ready byte stream.
`timescale 1ns/1ps
module dpram_word_serializer
  import dpram_drain_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              shift,
  input  logic              clear,
  input  logic [WORD_W-1:0] word,
  output logic [BYTE_W-1:0] byte_out,
  output logic              byte_valid,
  output logic [1:0]        byte_idx
);

  logic [WORD_W-1:0] sh_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_q       <= '0;
      byte_valid <= 1'b0;
      byte_idx   <= 2'd0;
    end else if (load) begin
      sh_q       <= word;
      byte_valid <= 1'b1;
      byte_idx   <= 2'd0;
    end else if (clear) begin
      byte_valid <= 1'b0;
    end else if (shift) begin
      sh_q     <= {sh_q[WORD_W-BYTE_W-1:0], BYTE_W'(0)};
      byte_idx <= byte_idx + 2'd1;
    end
  end

  assign byte_out = sh_q[WORD_W-1 -: BYTE_W];

endmodule

// File: rtl/dpram_drain.sv
// Drains a filled DPRAM buffer to the host byte link and hands ownership back.
`timescale 1ns/1ps
module dpram_drain
  import dpram_drain_pkg::*;
#(
  parameter int unsigned ADDR_W = DPRAM_ADDR_W,
  parameter int unsigned LEN_W  = DPRAM_LEN_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              dpram_run,
  input  logic [LEN_W-1:0]  dpram_len,
  output logic              dpram_busy,
  output logic              dpram_done,
  output logic [ADDR_W-1:0] dpram_rd_addr,
  input  logic [31:0]       dpram_rd_data,
  output logic [7:0]        byte_out,
  output logic              byte_valid,
  input  logic              byte_ready,
  output logic              len_err,
  output logic [LEN_W-1:0]  bytes_sent
);

  localparam int unsigned CAP_BYTES = byte_cap(ADDR_W);

  drain_state_t     state;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] len_eff_c;
  logic [LEN_W-1:0] sent_next_c;
  logic             over_c;
  logic             hs_c;
  logic             last_c;
  logic             load_c;
  logic             shift_c;
  logic             clear_c;
  logic [1:0]       byte_idx;

  // Over-long requests are clamped to the buffer size and flagged.
  assign over_c      = 32'(dpram_len) > CAP_BYTES;
  assign len_eff_c   = over_c ? LEN_W'(CAP_BYTES) : dpram_len;
  assign sent_next_c = bytes_sent + LEN_W'(1);

  assign hs_c    = (state == ST_SEND) && byte_valid && byte_ready;
  assign last_c  = hs_c && (sent_next_c == len_q);
  assign load_c  = (state == ST_LATCH);
  assign clear_c = hs_c && (last_c || (byte_idx == 2'd3));
  assign shift_c = hs_c && !clear_c;

  dpram_word_serializer u_ser (
    .clk        (clk),
    .rst        (rst),
    .load       (load_c),
    .shift      (shift_c),
    .clear      (clear_c),
    .word       (dpram_rd_data),
    .byte_out   (byte_out),
    .byte_valid (byte_valid),
    .byte_idx   (byte_idx)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_IDLE;
      len_q         <= '0;
      dpram_busy    <= 1'b0;
      dpram_done    <= 1'b0;
      dpram_rd_addr <= '0;
      len_err       <= 1'b0;
      bytes_sent    <= '0;
    end else begin
      dpram_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (dpram_run) begin
            len_q         <= len_eff_c;
            bytes_sent    <= '0;
            dpram_rd_addr <= '0;
            dpram_busy    <= 1'b1;
            if (over_c) len_err <= 1'b1;
            state <= (len_eff_c == '0) ? ST_FIN : ST_FETCH;
          end
        end
        ST_FETCH: state <= ST_LATCH;
        ST_LATCH: begin
          dpram_rd_addr <= dpram_rd_addr + ADDR_W'(1);
          state         <= ST_SEND;
        end
        ST_SEND: begin
          if (hs_c) begin
            bytes_sent <= sent_next_c;
            if (last_c)                 state <= ST_FIN;
            else if (byte_idx == 2'd3)  state <= ST_FETCH;
          end
        end
        ST_FIN: begin
          dpram_busy <= 1'b0;
          dpram_done <= 1'b1;
          state      <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
